// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM-stage load/store unit with req/ready data bus.
// Ports: clk/rst (sync, active-high); EX/MEM inputs load_mem, store_mem,
//   funct3_mem, alu_data_mem, rs2_data_mem; pipeline outputs stall_mem,
//   load_data_mem, load_valid_mem, misaligned_fault; data bus dbus_req,
//   dbus_we, dbus_addr, dbus_wdata, dbus_be, dbus_ready, dbus_rdata.
// Option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
//   instead of forcing alignment.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_mem,
   input  logic              store_mem,
   input  logic [2:0]        funct3_mem,
   input  logic [31:0]       alu_data_mem,
   input  logic [31:0]       rs2_data_mem,
   output logic              stall_mem,
   output logic [31:0]       load_data_mem,
   output logic              load_valid_mem,
   output logic              misaligned_fault,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [31:0]       dbus_wdata,
   output logic [3:0]        dbus_be,
   input  logic              dbus_ready,
   input  logic [31:0]       dbus_rdata
);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_t;

   state_t            r_state;
   state_t            w_next;

   logic              w_access;
   logic              w_misal;
   logic              w_pending;
   size_t             w_size;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [ADDR_W-1:0] w_addr;

   // Access attributes kept for shaping the read data in REQ.
   size_t             r_size;
   logic [1:0]        r_off;
   logic              r_sext;

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_ext;

   assign w_access = load_mem | store_mem;
   assign w_addr   = alu_data_mem[ADDR_W-1:0];

   // funct3[1:0] picks the size; codes 01x/11x all fall to word.
   always_comb begin
      w_size = SZ_W;
      case (funct3_mem[1:0])
         2'b00:   w_size = SZ_B;
         2'b01:   w_size = SZ_H;
         default: w_size = SZ_W;
      endcase
   end

   // Lane mask and replicated store data; halfword ignores addr[0].
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = rs2_data_mem;
      case (w_size)
         SZ_B: begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {4{rs2_data_mem[7:0]}};
         end
         SZ_H: begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{rs2_data_mem[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = rs2_data_mem;
         end
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      w_misal = 1'b0;
      case (w_size)
         SZ_H:    w_misal = w_addr[0];
         SZ_W:    w_misal = (w_addr[1:0] != 2'b00);
         default: w_misal = 1'b0;
      endcase
   end
`else
   assign w_misal = 1'b0;
`endif

   assign w_pending = w_access & ~w_misal;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; dbus_ready is only meaningful in REQ.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_pending ? S_REQ : S_IDLE;
         S_REQ:   w_next = dbus_ready ? S_IDLE : S_REQ;
         default: w_next = S_IDLE;
      endcase
   end

   // Bus registers: captured on issue, held through REQ.
   // Only dbus_req drops on completion; the rest keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_be    <= '0;
         r_size     <= SZ_W;
         r_off      <= 2'b00;
         r_sext     <= 1'b0;
      end else if (r_state == S_IDLE && w_pending) begin
         dbus_req   <= 1'b1;
         dbus_we    <= store_mem;
         dbus_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
         dbus_wdata <= w_wdata;
         dbus_be    <= w_be;
         r_size     <= w_size;
         r_off      <= w_addr[1:0];
         r_sext     <= ~funct3_mem[2];
      end else if (r_state == S_REQ && dbus_ready) begin
         dbus_req   <= 1'b0;
      end
   end

   // Read-data lane select and extension
   always_comb begin
      w_byte = dbus_rdata[7:0];
      case (r_off)
         2'd0: w_byte = dbus_rdata[7:0];
         2'd1: w_byte = dbus_rdata[15:8];
         2'd2: w_byte = dbus_rdata[23:16];
         2'd3: w_byte = dbus_rdata[31:24];
         default: w_byte = dbus_rdata[7:0];
      endcase
   end

   assign w_half = r_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

   always_comb begin
      w_ext = dbus_rdata;
      case (r_size)
         SZ_B:    w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
         SZ_H:    w_ext = {{16{r_sext & w_half[15]}}, w_half};
         default: w_ext = dbus_rdata;
      endcase
   end

   // Output logic
   always_comb begin
      stall_mem        = 1'b0;
      load_valid_mem   = 1'b0;
      load_data_mem    = '0;
      misaligned_fault = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall_mem        = w_pending;
            misaligned_fault = w_access & w_misal;
         end
         S_REQ: begin
            stall_mem = ~dbus_ready;
            // An abandoned request under reset never reports data.
            if (dbus_ready && !dbus_we && !rst) begin
               load_valid_mem = 1'b1;
               load_data_mem  = w_ext;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a
// load-result scoreboard checked whenever load_valid_mem is seen.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        load_mem;
   logic        store_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] alu_data_mem;
   logic [31:0] rs2_data_mem;
   logic        stall_mem;
   logic [31:0] load_data_mem;
   logic        load_valid_mem;
   logic        misaligned_fault;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ready;
   logic [31:0] dbus_rdata;

   int          n_checks = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   logic [31:0] sb[$];

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .load_mem         (load_mem),
      .store_mem        (store_mem),
      .funct3_mem       (funct3_mem),
      .alu_data_mem     (alu_data_mem),
      .rs2_data_mem     (rs2_data_mem),
      .stall_mem        (stall_mem),
      .load_data_mem    (load_data_mem),
      .load_valid_mem   (load_valid_mem),
      .misaligned_fault (misaligned_fault),
      .dbus_req         (dbus_req),
      .dbus_we          (dbus_we),
      .dbus_addr        (dbus_addr),
      .dbus_wdata       (dbus_wdata),
      .dbus_be          (dbus_be),
      .dbus_ready       (dbus_ready),
      .dbus_rdata       (dbus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every load_valid pops one expected result; otherwise
   // the load result must read as zero.
   always @(negedge clk) begin
      if (mon_en) begin
         if (load_valid_mem) begin
            n_checks++;
            assert (sb.size() != 0) else begin
               n_err++;
               $error("FAIL sb_unexpected_valid observed=%h expected=none",
                      load_data_mem);
            end
            if (sb.size() != 0) chk("load_data", load_data_mem, sb.pop_front());
         end else begin
            chk("load_zero", load_data_mem, 32'h0);
         end
      end
   end

   // Runs one access; called and returns 1 time unit after a posedge.
   task automatic do_access(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int nw,
                            input logic [31:0] rd, input logic [31:0] xaddr,
                            input logic [3:0] xbe, input logic [31:0] xwd);
      int stalls;
      logic [31:0] a0;
      logic [3:0]  be0;
      stalls       = 0;
      load_mem     = ld;
      store_mem    = st;
      funct3_mem   = f3;
      alu_data_mem = a;
      rs2_data_mem = wd;
      dbus_ready   = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_req"}, dbus_req, 0);
      chk({tag, "_fault"}, misaligned_fault, 0);
      if (stall_mem) stalls++;
      @(posedge clk); #1;
      chk({tag, "_req"}, dbus_req, 1);
      chk({tag, "_we"}, dbus_we, st);
      chk({tag, "_addr"}, dbus_addr, xaddr);
      chk({tag, "_be"}, dbus_be, xbe);
      if (st) chk({tag, "_wdata"}, dbus_wdata, xwd);
      a0  = dbus_addr;
      be0 = dbus_be;
      for (int i = 0; i < nw; i++) begin
         @(negedge clk);
         if (stall_mem) stalls++;
         chk({tag, "_hold_req"}, dbus_req, 1);
         chk({tag, "_hold_addr"}, dbus_addr, a0);
         chk({tag, "_hold_be"}, dbus_be, be0);
         @(posedge clk); #1;
      end
      dbus_ready = 1'b1;
      dbus_rdata = rd;
      @(negedge clk);
      if (stall_mem) stalls++;
      @(posedge clk); #1;
      load_mem   = 1'b0;
      store_mem  = 1'b0;
      dbus_ready = 1'b0;
      dbus_rdata = 32'h0;
      chk({tag, "_stall_cycles"}, stalls, nw + 1);
      chk({tag, "_req_drop"}, dbus_req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      load_mem     = 1'b0;
      store_mem    = 1'b0;
      funct3_mem   = 3'b010;
      alu_data_mem = 32'h0;
      rs2_data_mem = 32'h0;
      dbus_ready   = 1'b0;
      dbus_rdata   = 32'h0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst_req", dbus_req, 0);
      chk("rst_we", dbus_we, 0);
      chk("rst_addr", dbus_addr, 0);
      chk("rst_wdata", dbus_wdata, 0);
      chk("rst_be", dbus_be, 0);
      chk("rst_stall", stall_mem, 0);
      chk("rst_valid", load_valid_mem, 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Ready in IDLE with nothing pending must be ignored.
      dbus_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready_req", dbus_req, 0);
      chk("idle_ready_stall", stall_mem, 0);
      dbus_ready = 1'b0;

      do_access("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0,
                32'h100, 4'b1111, 32'hDEADBEEF);
      do_access("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0,
                32'h100, 4'b1000, 32'hA5A5A5A5);
      sb.push_back(32'hFFFFFF80);
      do_access("lb", 1, 0, 3'b000, 32'h102, 32'h0, 0, 32'h0080FF00,
                32'h100, 4'b0100, 32'h0);
      sb.push_back(32'h00000080);
      do_access("lbu", 1, 0, 3'b100, 32'h102, 32'h0, 0, 32'h0080FF00,
                32'h100, 4'b0100, 32'h0);
      sb.push_back(32'h0000007F);
      do_access("lb_pos", 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h7F000000,
                32'h100, 4'b1000, 32'h0);
      sb.push_back(32'hFFFF8001);
      do_access("lh", 1, 0, 3'b001, 32'h106, 32'h0, 3, 32'h80011234,
                32'h104, 4'b1100, 32'h0);
      do_access("sh", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0,
                32'h100, 4'b1100, 32'hABCDABCD);
      sb.push_back(32'h0000F00F);
      do_access("lhu", 1, 0, 3'b101, 32'h200, 32'h0, 1, 32'h0000F00F,
                32'h200, 4'b0011, 32'h0);
      sb.push_back(32'hCAFEF00D);
      do_access("lw", 1, 0, 3'b010, 32'h300, 32'h0, 2, 32'hCAFEF00D,
                32'h300, 4'b1111, 32'h0);
      do_access("ldst", 1, 1, 3'b010, 32'h400, 32'h55AA55AA, 0, 32'h0,
                32'h400, 4'b1111, 32'h55AA55AA);

      // Reset in the second wait cycle of a load: abandoned, no result.
      load_mem     = 1'b1;
      funct3_mem   = 3'b001;
      alu_data_mem = 32'h104;
      dbus_ready   = 1'b0;
      @(posedge clk); #1;
      chk("rmid_req1", dbus_req, 1);
      @(posedge clk); #1;
      rst      = 1'b1;
      load_mem = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rmid_req", dbus_req, 0);
      chk("rmid_stall", stall_mem, 0);
      sb.push_back(32'h89ABCDEF);
      do_access("post_rst", 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h89ABCDEF,
                32'h500, 4'b1111, 32'h0);

`ifdef MISALIGN_TRAP_EN
      load_mem     = 1'b1;
      funct3_mem   = 3'b010;
      alu_data_mem = 32'h101;
      @(negedge clk);
      chk("mis_fault", misaligned_fault, 1);
      chk("mis_stall", stall_mem, 0);
      @(posedge clk); #1;
      chk("mis_req", dbus_req, 0);
      chk("mis_fault2", misaligned_fault, 1);
      load_mem = 1'b0;
      @(posedge clk); #1;
      chk("mis_req2", dbus_req, 0);
`else
      sb.push_back(32'h11223344);
      do_access("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h11223344,
                32'h100, 4'b1111, 32'h0);
`endif

      @(posedge clk); #1;
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
